// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: recovers LSB-first frames from rx,
// presents each good byte on dout with rx_done_tick, flags a low stop bit with frame_err.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [4:0] S_MID      = 5'd7;
    localparam logic [4:0] S_BIT_END  = 5'd15;
    localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST     = 3'(DBIT - 1);

    logic            sync1_q;
    logic            rx_s_q;
    logic            rx_dly_q;
    logic            fall_edge;

    state_t          state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    // Only a high-to-low transition starts a frame, so a held-low line
    // (break, or the tail of a framing error) cannot retrigger the receiver.
    assign fall_edge = rx_dly_q & ~rx_s_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    state_d = START;
                    s_d     = 5'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = 5'd0;
                            n_d     = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d = 5'd0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_END) begin
                        state_d = IDLE;
                        if (rx_s_q) begin
                            dout_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_dly_q <= 1'b1;
            state_q  <= IDLE;
            s_q      <= 5'd0;
            n_q      <= 3'd0;
            b_q      <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            rx_dly_q <= rx_s_q;
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames driven tick-aligned from a divide-by-4 tick source.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    logic       tick_en;
    logic [1:0] tcnt;
    int         tick_num;

    int         n_tests;
    int         n_fail;

    int         done_cnt;
    int         ferr_cnt;
    int         both_cnt;
    int         wide_cnt;
    int         done_tick_at;
    logic       done_prev;
    logic       ferr_prev;
    logic [7:0] rxq[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud generator model, M = 4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt   <= 2'd0;
            s_tick <= 1'b0;
        end else begin
            tcnt   <= tcnt + 2'd1;
            s_tick <= tick_en && (tcnt == 2'd3);
        end
    end

    always @(posedge clk) begin
        if (s_tick) tick_num <= tick_num + 1;
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt     = done_cnt + 1;
            done_tick_at = tick_num;
            rxq.push_back(dout);
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (rx_done_tick && frame_err) both_cnt = both_cnt + 1;
        if ((rx_done_tick && done_prev) || (frame_err && ferr_prev)) wide_cnt = wide_cnt + 1;
        done_prev = rx_done_tick;
        ferr_prev = frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int k);
        repeat (k) @(posedge clk iff s_tick);
        #1;
    endtask

    task automatic send_rest(input logic [7:0] data, input logic stop_val);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
        rx = stop_val;
        wait_ticks(16);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_val);
        rx = 1'b0;
        wait_ticks(16);
        send_rest(data, stop_val);
    endtask

    int d0, f0, t0;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        done_cnt  = 0;
        ferr_cnt  = 0;
        both_cnt  = 0;
        wide_cnt  = 0;
        done_prev = 1'b0;
        ferr_prev = 1'b0;
        tick_num  = 0;
        tick_en   = 1'b1;
        rx        = 1'b1;
        rst_n     = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_done", {31'd0, rx_done_tick}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Good frame 0xA5; done expected 152 ticks after the falling edge
        d0 = done_cnt; f0 = ferr_cnt;
        t0 = tick_num;
        send_byte(8'hA5, 1'b1);
        wait_ticks(2);
        check("good_done_cnt", done_cnt - d0, 1);
        check("good_dout", {24'd0, dout}, 32'hA5);
        check("good_ferr_cnt", ferr_cnt - f0, 0);
        check("good_latency", done_tick_at - t0, 152);

        // Glitch: 3 ticks low, then high
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(40);
        check("glitch_done_cnt", done_cnt - d0, 0);
        check("glitch_ferr_cnt", ferr_cnt - f0, 0);
        send_byte(8'h3C, 1'b1);
        wait_ticks(2);
        check("after_glitch_done_cnt", done_cnt - d0, 1);
        check("after_glitch_dout", {24'd0, dout}, 32'h3C);

        // Framing error after a good 0xA5, then a 200-tick break
        send_byte(8'hA5, 1'b1);
        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'h12, 1'b0);
        check("ferr_cnt", ferr_cnt - f0, 1);
        check("ferr_done_cnt", done_cnt - d0, 0);
        check("ferr_dout_held", {24'd0, dout}, 32'hA5);
        wait_ticks(200);
        check("break_ferr_cnt", ferr_cnt - f0, 1);
        check("break_done_cnt", done_cnt - d0, 0);
        rx = 1'b1;
        wait_ticks(8);
        send_byte(8'h81, 1'b1);
        wait_ticks(2);
        check("post_break_done_cnt", done_cnt - d0, 1);
        check("post_break_dout", {24'd0, dout}, 32'h81);

        // Back-to-back with one stop bit
        d0 = done_cnt;
        rxq.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_ticks(2);
        check("b2b_done_cnt", done_cnt - d0, 2);
        check("b2b_first", {24'd0, (rxq.size() > 0) ? rxq[0] : 8'hEE}, 32'h00);
        check("b2b_second", {24'd0, (rxq.size() > 1) ? rxq[1] : 8'hEE}, 32'hFF);

        // Reset after 4 data bits of 0x77
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 3) ? 1'b0 : 1'b1;
            wait_ticks(16);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_dout", {24'd0, dout}, 32'h00);
        check("midrst_done", {31'd0, rx_done_tick}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ticks(200);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_ferr", ferr_cnt - f0, 0);
        send_byte(8'h5A, 1'b1);
        wait_ticks(2);
        check("post_rst_dout", {24'd0, dout}, 32'h5A);
        check("post_rst_done_cnt", done_cnt - d0, 1);

        // Tick starvation right after the start edge
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        tick_en = 1'b1;
        wait_ticks(16);
        send_rest(8'hC3, 1'b1);
        wait_ticks(2);
        check("starve_done_cnt", done_cnt - d0, 1);
        check("starve_ferr_cnt", ferr_cnt - f0, 0);
        check("starve_dout", {24'd0, dout}, 32'hC3);

        check("mutex", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
